display_scanner: RTL and testbench
==================================

DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 Parameter REFRESH_DIV, default 50000, meaning src_clk cycles per digit slot (2 kHz digit rate at 100 MHz); legal range 2..2^20.
REQ-002 Parameter BLINK_FRAMES, default 128, meaning full 4-digit frames per blink half-period; legal range 1..2^16.
REQ-003 src_clk  input  1  the single clock; all state SHALL be clocked on its rising edge.
REQ-004 src_rst_n  input  1  asynchronous, active-low reset; assertion SHALL clear state immediately, and deassertion is synchronous to src_clk.
REQ-005 digits  input  16  four BCD digits; digit k = digits[4k+3:4k], digit 0 = rightmost.
REQ-006 dps  input  4  decimal-point request per digit, bit k = digit k.
REQ-007 blink  input  4  dp blink enable per digit, bit k = digit k.
REQ-008 load  input  1  single-cycle strobe capturing digits/dps/blink into the pending registers.
REQ-009 select  output  2  registered slot index driven to the downstream seven-segment stage.
REQ-010 digit_val  output  4  registered digit value for the current slot.
REQ-011 dp  output  1  registered decimal-point value for the current slot, active-high.
REQ-012 frame_done  output  1  one-cycle pulse marking the start of a new frame.

Function
REQ-013 A tick counter SHALL count 0..REFRESH_DIV-1 and wrap; the cycle in which it equals REFRESH_DIV-1 is a "tick".
REQ-014 On each tick, select SHALL advance by 1 modulo 4 (3 wraps to 0); select SHALL hold between ticks.
REQ-015 On a tick where select goes 3->0 (a "boundary"), the display registers (digits, dps, blink) SHALL take the pending values.
REQ-016 A load asserted in any cycle, including a boundary cycle, SHALL update the pending registers only; data loaded in a boundary cycle SHALL commit at the next boundary.
REQ-017 Multiple loads within one frame: the last one before the boundary SHALL win.
REQ-018 digit_val, dp and select SHALL update in the same edge, so digit_val/dp always correspond to the select value they accompany; at a boundary they SHALL use the newly committed data (zero-latency commit to slot 0).
REQ-019 digit_val SHALL pass the 4-bit value unmodified, including values 10..15.
REQ-020 A frame counter SHALL count boundaries 0..BLINK_FRAMES-1 and wrap; on wrap, blink_phase SHALL toggle.
REQ-021 dp SHALL equal dps[k] AND NOT(blink[k] AND blink_phase) for the slot k being output.
REQ-022 frame_done SHALL be high for exactly the one cycle after the boundary edge (coincident with select becoming 0) and low otherwise.

Reset
REQ-023 While src_rst_n=0: tick counter, frame counter, blink_phase, pending and display registers SHALL be 0; select=0, digit_val=0, dp=0, frame_done=0.
REQ-024 Reset asserted mid-frame SHALL abandon the frame; after release the first tick SHALL occur REFRESH_DIV cycles later and move select to 1.
REQ-025 load sampled in the cycle reset releases SHALL be captured normally.

Verification (REFRESH_DIV=4, BLINK_FRAMES=2)
REQ-026 Release reset, no load -> select sequence 0,1,2,3,0 changing every 4 cycles; digit_val=0, dp=0 throughout; frame_done pulses every 16 cycles.
REQ-027 load digits=16'h4321, dps=4'b0100 mid-frame -> old values until next boundary, then slots 0..3 show 1,2,3,4 with dp=1 only at select=2.
REQ-028 load coincident with boundary, digits=16'h9999 -> current frame keeps previous data; 9s appear from the following boundary.
REQ-029 dps=4'b0001, blink=4'b0001 -> dp at select=0 is 1 for 2 frames, 0 for 2 frames, repeating; other slots dp=0.
REQ-030 Assert src_rst_n=0 at select=2 mid-slot -> outputs go 0 asynchronously without waiting for a clock edge; after release select reaches 1 exactly 4 cycles later.
REQ-031 digits=16'hFEDC loaded -> digit_val shows C,D,E,F unmodified on slots 0..3.

Source files
------------

// File: rtl/display_scanner.sv
// display_scanner: four-digit multiplexed display scanner with frame-aligned data
// commit and per-digit decimal-point blinking.
module display_scanner #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 128
) (
    input  logic        src_clk,
    input  logic        src_rst_n,
    input  logic [15:0] digits,
    input  logic [3:0]  dps,
    input  logic [3:0]  blink,
    input  logic        load,
    output logic [1:0]  select,
    output logic [3:0]  digit_val,
    output logic        dp,
    output logic        frame_done
);
    localparam int TW = $clog2(REFRESH_DIV);
    localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;

    logic [TW-1:0] tick_q, tick_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          phase_q, phase_d;
    logic [1:0]    sel_q, sel_d;
    logic [15:0]   pend_dig_q, pend_dig_d, disp_dig_q, disp_dig_d;
    logic [3:0]    pend_dps_q, pend_dps_d, disp_dps_q, disp_dps_d;
    logic [3:0]    pend_blk_q, pend_blk_d, disp_blk_q, disp_blk_d;
    logic [3:0]    digit_val_q, digit_val_d;
    logic          dp_q, dp_d;
    logic          frame_done_q, frame_done_d;
    logic          tick, boundary, frame_wrap;

    always_comb begin
        tick         = tick_q == TW'(REFRESH_DIV - 1);
        boundary     = tick && sel_q == 2'd3;
        frame_wrap   = boundary && frame_q == FW'(BLINK_FRAMES - 1);
        tick_d       = tick ? '0 : tick_q + 1'b1;
        sel_d        = sel_q + {1'b0, tick};
        pend_dig_d   = load ? digits : pend_dig_q;
        pend_dps_d   = load ? dps : pend_dps_q;
        pend_blk_d   = load ? blink : pend_blk_q;
        // commit uses the pending value from before this edge, so a coincident load waits a frame
        disp_dig_d   = boundary ? pend_dig_q : disp_dig_q;
        disp_dps_d   = boundary ? pend_dps_q : disp_dps_q;
        disp_blk_d   = boundary ? pend_blk_q : disp_blk_q;
        frame_d      = frame_wrap ? '0 : boundary ? frame_q + 1'b1 : frame_q;
        phase_d      = phase_q ^ frame_wrap;
        // outputs are built from next-state values so slot 0 sees freshly committed data
        digit_val_d  = disp_dig_d[{sel_d, 2'b00} +: 4];
        dp_d         = disp_dps_d[sel_d] & ~(disp_blk_d[sel_d] & phase_d);
        frame_done_d = boundary;
    end

    always_ff @(posedge src_clk or negedge src_rst_n) begin
        if (!src_rst_n) begin
            tick_q       <= '0;
            frame_q      <= '0;
            phase_q      <= 1'b0;
            sel_q        <= '0;
            pend_dig_q   <= '0;
            pend_dps_q   <= '0;
            pend_blk_q   <= '0;
            disp_dig_q   <= '0;
            disp_dps_q   <= '0;
            disp_blk_q   <= '0;
            digit_val_q  <= '0;
            dp_q         <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            tick_q       <= tick_d;
            frame_q      <= frame_d;
            phase_q      <= phase_d;
            sel_q        <= sel_d;
            pend_dig_q   <= pend_dig_d;
            pend_dps_q   <= pend_dps_d;
            pend_blk_q   <= pend_blk_d;
            disp_dig_q   <= disp_dig_d;
            disp_dps_q   <= disp_dps_d;
            disp_blk_q   <= disp_blk_d;
            digit_val_q  <= digit_val_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign select     = sel_q;
    assign digit_val  = digit_val_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_display_scanner.sv
// tb_display_scanner: scoreboard bench for display_scanner against a cycle-count model.
module tb_display_scanner;
    localparam int RD = 4;
    localparam int BF = 2;
    localparam int FR = 4 * RD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] digits = '0;
    logic [3:0]  dps = '0;
    logic [3:0]  blink = '0;
    logic [1:0]  select;
    logic [3:0]  digit_val;
    logic        dp;
    logic        frame_done;

    display_scanner #(.REFRESH_DIV(RD), .BLINK_FRAMES(BF)) dut (
        .src_clk(clk), .src_rst_n(rst_n), .digits(digits), .dps(dps), .blink(blink),
        .load(load), .select(select), .digit_val(digit_val), .dp(dp), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          fails = 0;
    int          n = 0;
    logic [23:0] pend = '0;
    logic [23:0] disp = '0;
    logic [7:0]  q[$];
    logic [7:0]  mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: n counts clock edges since reset release; slot and frame follow from plain division.
    task automatic step(input bit ld, input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        int sel, ph;
        logic [7:0] e;
        @(negedge clk);
        rst_n = 1'b1; load = ld; digits = d; dps = p; blink = b;
        @(posedge clk);
        n++;
        if (n % FR == 0) disp = pend;
        if (ld) pend = {b, p, d};
        sel = (n / RD) % 4;
        ph = (n / FR / BF) % 2;
        e[7:6] = 2'(sel);
        e[5:2] = disp[4*sel +: 4];
        e[1] = disp[16+sel] & ~(disp[20+sel] & ph[0]);
        e[0] = (n % FR == 0);
        q.push_back(e);
    endtask

    task automatic idle(input int k);
        repeat (k) step(1'b0, digits, dps, blink);
    endtask

    always @(negedge clk) begin
        if (rst_n && q.size() > 0) begin
            mon_e = q.pop_front();
            chk("select", 32'(select), 32'(mon_e[7:6]));
            chk("digit_val", 32'(digit_val), 32'(mon_e[5:2]));
            chk("dp", 32'(dp), 32'(mon_e[1]));
            chk("frame_done", 32'(frame_done), 32'(mon_e[0]));
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_select", 32'(select), 0);
        chk("rst_digit_val", 32'(digit_val), 0);
        chk("rst_dp", 32'(dp), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        step(1'b1, 16'h4321, 4'b0100, 4'b0000);
        idle(40);
        step(1'b1, 16'hFEDC, 4'b0000, 4'b0000);
        idle(30);
        while ((n + 1) % FR != 0) idle(1);
        step(1'b1, 16'h9999, 4'b0000, 4'b0000);
        idle(40);
        step(1'b1, 16'h0000, 4'b0001, 4'b0001);
        idle(100);
        repeat (500) step($urandom_range(0, 5) == 0, 16'($urandom), 4'($urandom), 4'($urandom));
        while (!(((n / RD) % 4) == 2 && n % RD == 1)) idle(1);
        #2 rst_n = 1'b0;
        q.delete();
        #1;
        chk("async_select", 32'(select), 0);
        chk("async_digit_val", 32'(digit_val), 0);
        chk("async_dp", 32'(dp), 0);
        chk("async_frame_done", 32'(frame_done), 0);
        n = 0; pend = '0; disp = '0;
        repeat (2) @(posedge clk);
        idle(3);
        #1 chk("select_before_first_tick", 32'(select), 0);
        idle(1);
        #1 chk("select_first_tick", 32'(select), 1);
        idle(20);
        @(negedge clk);
        #1 chk("scoreboard_drain", 32'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
